fpu_op_scheduler: RTL and testbench

FPU_OP_SCHEDULER -- requirements
Module: fpu_op_scheduler

---
 rtl/fpu_op_scheduler.sv | 174 +++++++++++++++++
 tb/tb_fpu_op_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fpu_op_scheduler
// Description : Shares one combinational single-precision FP ALU between two
//               requesters. A granted request is held on the ALU inputs for
//               WAIT_CYCLES cycles, the ALU outputs are captured on the last
//               of those cycles, and the result is offered on a valid/ready
//               response port. Illegal opcodes bypass the ALU and answer with
//               a quiet NaN and the exception flag.
//               Build macro FPU_SCHED_RR_ARB_EN: round-robin arbitration when
//               defined, fixed priority (requester 0 wins) otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_op_scheduler #(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_exception,
    input  logic        alu_overflow,
    input  logic        alu_underflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [2:0]  rsp_flags,
    output logic        busy
);

    localparam logic [1:0]  c_ST_IDLE       = 2'd0;
    localparam logic [1:0]  c_ST_EXEC       = 2'd1;
    localparam logic [1:0]  c_ST_RESP       = 2'd2;
    localparam logic [31:0] c_QNAN          = 32'h7FC0_0000;
    localparam logic [2:0]  c_ILLEGAL_FLAGS = 3'b100;
    localparam logic [3:0]  c_WAIT          = 4'(WAIT_CYCLES);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_id;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_result;
    logic [2:0]  r_rsp_flags;

    logic        w_grant_id;
    logic        w_accept;
    logic [3:0]  w_sel_op;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;
    logic        w_sel_legal;
    logic        w_exec;

`ifdef FPU_SCHED_RR_ARB_EN
    // Requester granted most recently; reset to 1 so requester 0 wins first
    logic r_last_grant;

    // Round-robin choice: on contention pick the requester not served last
    always_comb begin
        w_grant_id = 1'b0;
        if (req_valid == 2'b11) begin
            w_grant_id = ~r_last_grant;
        end else if (req_valid[1]) begin
            w_grant_id = 1'b1;
        end
    end

    // Remember the winner of every accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
        end
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is idle
    assign w_grant_id = req_valid[1] & ~req_valid[0];
`endif

    // Grants happen only in IDLE, and never while reset is applied
    assign w_accept  = (r_state == c_ST_IDLE) && (|req_valid) && !rst;
    assign req_ready = w_accept ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;

    assign w_sel_op    = w_grant_id ? req_op[7:4]  : req_op[3:0];
    assign w_sel_a     = w_grant_id ? req_a[63:32] : req_a[31:0];
    assign w_sel_b     = w_grant_id ? req_b[63:32] : req_b[31:0];
    assign w_sel_legal = (w_sel_op >= 4'd1) && (w_sel_op <= 4'd5);

    // The ALU sees operands only while executing; zero otherwise
    assign w_exec = (r_state == c_ST_EXEC);
    assign alu_op = w_exec ? r_op : 4'd0;
    assign alu_a  = w_exec ? r_a  : 32'd0;
    assign alu_b  = w_exec ? r_b  : 32'd0;

    assign busy       = (r_state != c_ST_IDLE) && !rst;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;

    // Scheduler FSM: accept, hold the ALU for WAIT_CYCLES, then present result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= 4'd0;
            r_op         <= 4'd0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 32'd0;
            r_rsp_flags  <= 3'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op <= w_sel_op;
                        r_a  <= w_sel_a;
                        r_b  <= w_sel_b;
                        r_id <= w_grant_id;
                        if (w_sel_legal) begin
                            r_cnt   <= c_WAIT;
                            r_state <= c_ST_EXEC;
                        end else begin
                            // Unknown opcode: answer immediately, ALU untouched
                            r_rsp_valid  <= 1'b1;
                            r_rsp_id     <= w_grant_id;
                            r_rsp_result <= c_QNAN;
                            r_rsp_flags  <= c_ILLEGAL_FLAGS;
                            r_state      <= c_ST_RESP;
                        end
                    end
                end
                c_ST_EXEC: begin
                    if (r_cnt == 4'd1) begin
                        // Operands have been stable long enough; sample the ALU
                        r_cnt        <= 4'd0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_id     <= r_id;
                        r_rsp_result <= alu_result;
                        r_rsp_flags  <= {alu_exception, alu_overflow, alu_underflow};
                        r_state      <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_op_scheduler
// Description : Self-checking bench for fpu_op_scheduler. A stand-in ALU
//               answers known IEEE vectors exactly and hashes anything else;
//               expected responses, latencies and grants come from a
//               transaction-level model. Honours FPU_SCHED_RR_ARB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_op_scheduler;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_exception;
    logic        alu_overflow;
    logic        alu_underflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int last_grant = 1;

    fpu_op_scheduler #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_exception(alu_exception),
        .alu_overflow(alu_overflow), .alu_underflow(alu_underflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: {exception, overflow, underflow, result}
    function automatic logic [34:0] fake_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 4'd1 && a == 32'h3FC00000 && b == 32'h40100000) return {3'b000, 32'h40700000};
        if (op == 4'd3 && a == 32'h40000000 && b == 32'h40400000) return {3'b000, 32'h40C00000};
        if (op == 4'd5 && a == 32'h40800000) return {3'b000, 32'h40000000};
        if (op >= 4'd1 && op <= 4'd5)
            return {a[0] & b[0], (op == 4'd3) & a[1] & b[1], (op == 4'd3) & a[2] & ~b[2],
                    (a ^ {b[15:0], b[31:16]}) + ({28'd0, op} * 32'h01010101)};
        return {3'b111, 32'hDEADBEEF};
    endfunction

    always_comb {alu_exception, alu_overflow, alu_underflow, alu_result} = fake_alu(alu_op, alu_a, alu_b);

    function automatic bit is_legal(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic logic [34:0] expected_rsp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (is_legal(op)) return fake_alu(op, a, b);
        return {3'b100, 32'h7FC00000};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic present(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[4*id +: 4]  = op;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid[id]      = 1'b1;
    endtask

    // Called just after a negedge; returns the granted requester or -1
    task automatic wait_grant(output int gid);
        gid = -1;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (req_ready != 2'b00) begin
                gid = req_ready[1] ? 1 : 0;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Follows an accepted request to its response and completes the handshake
    task automatic finish_txn(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input int hold, input bit drop_valid, input bit poke_other);
        logic [34:0] e;
        int lat;
        int alu_cycles;
        e          = expected_rsp(op, a, b);
        lat        = 0;
        alu_cycles = 0;
        @(negedge clk);
        if (drop_valid) req_valid[id] = 1'b0;
        if (poke_other) req_valid[1-id] = 1'b1;
        #1;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            chk("busy_exec", busy, 1'b1);
            chk("no_grant_exec", req_ready, 2'b00);
            if (alu_op != 4'd0) begin
                alu_cycles++;
                chk("alu_op", alu_op, op);
                chk("alu_a", alu_a, a);
                if (op != 4'd5) chk("alu_b", alu_b, b);
            end
            @(negedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, is_legal(op) ? W + 1 : 1);
        chk("alu_cycles", alu_cycles, is_legal(op) ? W : 0);
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("alu_idle_resp", alu_op, 4'd0);
        chk("rsp_id", rsp_id, id[0]);
        chk("rsp_result", rsp_result, e[31:0]);
        chk("rsp_flags", rsp_flags, e[34:32]);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_id", rsp_id, id[0]);
            chk("stall_result", rsp_result, e[31:0]);
            chk("stall_flags", rsp_flags, e[34:32]);
            chk("stall_no_grant", req_ready, 2'b00);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("hs_no_grant", req_ready, 2'b00);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("rsp_dropped", rsp_valid, 1'b0);
        chk("busy_idle", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int exp_g;
        int id;
        bit saw_rsp;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ops [2];
        logic [31:0] as  [2];
        logic [31:0] bs  [2];

        // Reset with a pending request: nothing may be granted while rst=1
        rst = 1'b1; rsp_ready = 1'b0; req_valid = 2'b01;
        req_op = 8'h11; req_a = 64'd0; req_b = 64'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_flags", rsp_flags, 3'd0);
        chk("rst_alu_op", alu_op, 4'd0);
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b0;
        last_grant = 1;

        // 1.5 + 2.25 = 3.75 from requester 0
        @(negedge clk);
        present(0, 4'd1, 32'h3FC00000, 32'h40100000);
        wait_grant(g);
        chk("grant_add", g, 0);
        last_grant = 0;
        finish_txn(0, 4'd1, 32'h3FC00000, 32'h40100000, 0, 1'b1, 1'b0);

        // 2 * 3 = 6 from requester 1 with a 5-cycle stall; requester 0 waits
        req_op[3:0] = 4'd5; req_a[31:0] = 32'h40800000; req_b[31:0] = 32'h12345678;
        @(negedge clk);
        present(1, 4'd3, 32'h40000000, 32'h40400000);
        wait_grant(g);
        chk("grant_mul", g, 1);
        last_grant = 1;
        finish_txn(1, 4'd3, 32'h40000000, 32'h40400000, 5, 1'b1, 1'b1);

        // The waiting sqrt(4) = 2 is granted right after the handshake
        wait_grant(g);
        chk("grant_sqrt", g, 0);
        last_grant = 0;
        finish_txn(0, 4'd5, 32'h40800000, 32'h12345678, 0, 1'b1, 1'b0);

        // Illegal opcode 7
        @(negedge clk);
        present(0, 4'd7, 32'h3F800000, 32'h3F800000);
        wait_grant(g);
        chk("grant_illegal", g, 0);
        last_grant = 0;
        finish_txn(0, 4'd7, 32'h3F800000, 32'h3F800000, 1, 1'b1, 1'b0);

        // Randomised single-requester traffic
        for (int t = 0; t < 24; t++) begin
            id = int'($urandom_range(0, 1));
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 5));
            a  = $urandom;
            b  = $urandom;
            @(negedge clk);
            present(id, op, a, b);
            wait_grant(g);
            chk("grant_rand", g, id);
            last_grant = id;
            finish_txn(id, op, a, b, int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        // Reset in the 2nd EXEC cycle aborts the divide
        @(negedge clk);
        present(0, 4'd4, 32'h40400000, 32'h40000000);
        wait_grant(g);
        chk("grant_abort", g, 0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy_in_rst", busy, 1'b0);
        chk("abort_ready_in_rst", req_ready, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        last_grant = 1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_alu_op", alu_op, 4'd0);
        saw_rsp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) saw_rsp = 1'b1;
        end
        chk("abort_no_rsp", saw_rsp, 1'b0);

        // Both requesters valid for four back-to-back operations
        ops[0] = 4'd1; as[0] = $urandom; bs[0] = $urandom;
        ops[1] = 4'd3; as[1] = $urandom; bs[1] = $urandom;
        @(negedge clk);
        present(0, ops[0], as[0], bs[0]);
        present(1, ops[1], as[1], bs[1]);
        for (int k = 0; k < 4; k++) begin
`ifdef FPU_SCHED_RR_ARB_EN
            exp_g = 1 - last_grant;
`else
            exp_g = 0;
`endif
            wait_grant(g);
            chk("grant_contend", g, exp_g);
            last_grant = exp_g;
            finish_txn(exp_g, ops[exp_g], as[exp_g], bs[exp_g], 0, 1'b0, 1'b0);
        end
        req_valid = 2'b00;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
